seg7_scan_driver: RTL
=====================

Name: seg7_scan_driver

Overview:
- Time-multiplexed driver for the board's 8-digit common-anode seven-segment display.
- Takes a 32-bit word, typically a CPU register value selected by the board's switches, and renders it as 8 hex digits on o_seg/o_sel.
- It is the display (writer) end of the seg/sel interface that board-level benches decode back into digit values.
- Captures new data into a pending buffer and commits it only at frame boundaries, so a displayed frame never mixes old and new nibbles.

Parameters:
- CLK_DIV, 100000: clk cycles per digit slot. Legal range 2..2^24-1. Benches use 4.
- LZ_BLANK, 0: 1 blanks leading-zero digits 7..1. Digit 0 is always shown.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- ena  input  1  scan enable; low freezes the scan
- i_data  input  32  value to display
- i_load  input  1  one-cycle strobe; captures i_data
- o_seg  output  8  active-low segments: bit0=a .. bit6=g, bit7=dp (dp always off, =1)
- o_sel  output  8  active-low digit select; bit k = digit k (digit 0 rightmost)
- o_frame_done  output  1  one-cycle pulse when the digit index wraps 7->0

Behaviour:
- Reset (async, on rst high) clears the following:
  - div_cnt=0, digit=0, shadow=0, pending=0, pend_vld=0
  - o_seg=8'hFF, o_sel=8'hFF (display dark), o_frame_done=0
- Divider:
  - When ena=1, div_cnt increments each cycle.
  - When div_cnt==CLK_DIV-1, tick=1 and div_cnt returns to 0.
  - When ena=0, div_cnt, digit, shadow and all outputs hold. i_load is still accepted.
- Digit counter:
  - On tick, digit <= digit+1 modulo 8.
  - On the 7->0 wrap, o_frame_done=1 for that one cycle only.
- Outputs:
  - Registered, updated on the cycle after each tick: o_sel=~(8'b1<<digit_new), o_seg=enc(shadow nibble digit_new).
  - The first tick after reset selects digit 1 (digit_new = 1). Digit 0 is first driven at the wrap that ends the first frame.
- Encoding, active-low, nibble->o_seg:
  - 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8
  - 8:80 9:90 A:88 b:83 C:C6 d:A1 E:86 F:8E
- Blanking:
  - Applies only when LZ_BLANK=1.
  - Digit k>0 outputs o_seg=FF if all shadow nibbles k..7 are zero.
  - o_sel still strobes that digit.
- Load/commit:
  - i_load=1 sets pending<=i_data and pend_vld<=1. A later load overwrites pending (last write wins).
  - At a wrap tick with pend_vld=1: shadow<=pending, pend_vld<=0. The new nibble for digit 0 in that same output update comes from the new shadow.
  - Load in the same cycle as a wrap tick: i_data goes directly to shadow, pend_vld<=0.
  - At a wrap with no pending data, shadow is unchanged.
- Reset mid-frame: display goes dark immediately. Pending data is discarded.
- CLK_DIV<2 is illegal; no behaviour is defined for it.

Test Plan:
- Reset, then ena=1, CLK_DIV=4, no load:
  - Before the first tick: o_sel=FF, o_seg=FF.
  - After the first tick (cycle 5): o_sel=FD, o_seg=C0.
  - Digits cycle FE..7F every 4 clk. o_frame_done pulses every 32 clk.
- Load 32'h1234ABCD mid-frame, then one full frame:
  - o_seg stays C0 on all digits until the wrap.
  - Next frame, digit0..7 = A1,C6,83,88,99,B0,A4,F9.
- Two loads within one frame, 32'h1 then 32'h2:
  - Next frame digit0 = A4. No frame ever shows 1.
  - Load asserted exactly on a wrap tick commits in that same cycle.
- ena dropped for 20 cycles mid-digit:
  - o_sel, o_seg and div_cnt hold.
  - Resume completes the remaining slot count exactly.
  - A load issued while ena=0 is pending and commits at the next wrap.
- LZ_BLANK=1, data 32'h000000A5:
  - digit0=92, digit1=88, digits 2..7 o_seg=FF.
  - Data 0: digit0=C0, others FF.
- Assert rst while digit 5 is active and a load is pending:
  - o_sel=FF and o_seg=FF asynchronously, without waiting for a clk edge.
  - After release, display shows 0 (pending data discarded).

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 8-digit common-anode seven-segment driver.
// New data is committed only at frame boundaries so frames never tear.
module seg7_scan_driver #(
    parameter int CLK_DIV  = 100000,
    parameter bit LZ_BLANK = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic [31:0] i_data,
    input  logic        i_load,
    output logic [7:0]  o_seg,
    output logic [7:0]  o_sel,
    output logic        o_frame_done
);

    localparam logic [23:0] DIV_MAX = 24'(CLK_DIV - 1);

    logic [23:0] div_cnt;
    logic [2:0]  digit;
    logic [31:0] shadow;
    logic [31:0] pending;
    logic        pend_vld;

    logic        tick;
    logic        wrap;
    logic [2:0]  digit_nxt;
    logic [31:0] shadow_nxt;
    logic [31:0] shifted;
    logic        blank;
    logic [7:0]  seg_nxt;
    logic [7:0]  sel_nxt;

    function automatic logic [7:0] enc(input logic [3:0] n);
        logic [7:0] s;
        unique case (n)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            4'hF: s = 8'h8E;
        endcase
        return s;
    endfunction

    assign tick      = ena && (div_cnt == DIV_MAX);
    assign wrap      = tick && (digit == 3'd7);
    assign digit_nxt = digit + 3'd1;

    // Shadow value as seen by this cycle's output update (commit at wrap)
    always_comb begin
        shadow_nxt = shadow;
        if (wrap) begin
            if (i_load) begin
                shadow_nxt = i_data;
            end else if (pend_vld) begin
                shadow_nxt = pending;
            end
        end
    end

    // Segment/select pattern for the digit about to be shown
    always_comb begin
        shifted = shadow_nxt >> {digit_nxt, 2'b00};
        blank   = LZ_BLANK && (digit_nxt != 3'd0) && (shifted == 32'd0);
        seg_nxt = blank ? 8'hFF : enc(shifted[3:0]);
        sel_nxt = ~(8'd1 << digit_nxt);
    end

    // Slot divider and digit index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            digit   <= '0;
        end else if (ena) begin
            if (tick) begin
                div_cnt <= '0;
                digit   <= digit_nxt;
            end else begin
                div_cnt <= div_cnt + 24'd1;
            end
        end
    end

    // Pending capture and frame-boundary commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow   <= '0;
            pending  <= '0;
            pend_vld <= 1'b0;
        end else if (wrap) begin
            shadow   <= shadow_nxt;
            pend_vld <= 1'b0;
        end else if (i_load) begin
            pending  <= i_data;
            pend_vld <= 1'b1;
        end
    end

    // Registered display outputs, refreshed on each tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_seg        <= 8'hFF;
            o_sel        <= 8'hFF;
            o_frame_done <= 1'b0;
        end else begin
            o_frame_done <= wrap;
            if (tick) begin
                o_seg <= seg_nxt;
                o_sel <= sel_nxt;
            end
        end
    end

endmodule
